// File: rtl/beat32_pkg.sv
// Shared beat-timing constants for beat32 and the other note/beat timing blocks.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
package beat32_pkg;

   // Default tick period: short enough to observe in simulation.
   localparam int DEFAULT_PERIOD = 7;

   // Production timing: one beat is split into 32 subdivisions, so the
   // tick period is the system clock rate divided by 32.
   localparam int CLK_HZ         = 50_000_000;
   localparam int SUBDIV_PER_BEAT = 32;

   function automatic int period_from_clock(input int clk_hz, input int subdiv);
      return clk_hz / subdiv;
   endfunction

   localparam int PROD_PERIOD = period_from_clock(CLK_HZ, SUBDIV_PER_BEAT);

endpackage

// File: rtl/beat32_dff_r.sv
// Parameter-width D flip-flop with synchronous active-high reset to zero.
// Latency: 1 cycle from d to q.
// Backpressure: none, loads every cycle.
// Ports: clock (rising edge), reset (sync, active-high), d (next value), q (registered value).
module dff_r #(
   parameter int W = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clock) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/beat32.sv
// Free-running tick generator: one-cycle pulse on count every PERIOD clocks.
// Latency: first pulse PERIOD rising edges after reset is released.
// Backpressure: none; count is a clock-enable, not a handshake.
// Ports: clock (rising edge), reset (sync, active-high, priority over counting),
//        count (registered tick, high one cycle per PERIOD cycles).
module beat32
   import beat32_pkg::*;
#(
   parameter int PERIOD = DEFAULT_PERIOD
) (
   input  logic clock,
   input  logic reset,
   output logic count
);

   // Derived width; guarded so an illegal PERIOD still reaches the check below.
   localparam int CW = (PERIOD < 2) ? 1 : $clog2(PERIOD);

   generate
      if (PERIOD < 2) begin : g_bad_period
         $error("beat32: PERIOD must be at least 2");
      end
   endgenerate

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          tick;
   logic          tick_nxt;
   logic          wrap;

   // Explicit terminal compare so non-power-of-two periods wrap correctly.
   assign wrap = (cnt == CW'(PERIOD - 1));

   always_comb begin
      cnt_nxt  = cnt + CW'(1);
      tick_nxt = 1'b0;
      if (wrap) begin
         cnt_nxt  = '0;
         tick_nxt = 1'b1;
      end
   end

   dff_r #(.W(CW)) u_cnt (
      .clock (clock),
      .reset (reset),
      .d     (cnt_nxt),
      .q     (cnt)
   );

   dff_r #(.W(1)) u_tick (
      .clock (clock),
      .reset (reset),
      .d     (tick_nxt),
      .q     (tick)
   );

   // Output comes straight from a register; no input reaches it combinationally.
   assign count = tick;

endmodule

// File: tb/tb_beat32.sv
module tb_beat32;

   logic clock;
   logic reset;
   logic count7;
   logic count2;
   logic count32;

   beat32 #(.PERIOD(7))  dut7  (.clock(clock), .reset(reset), .count(count7));
   beat32 #(.PERIOD(2))  dut2  (.clock(clock), .reset(reset), .count(count2));
   beat32 #(.PERIOD(32)) dut32 (.clock(clock), .reset(reset), .count(count32));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks;
   int passed;

   // Reference model state: edges with reset low since the last reset edge.
   int  k7, k2, k32;
   bit  valid;
   int  pulses7;

   logic q7[$];
   logic q2[$];
   logic q32[$];
   int   qk[$];

   function automatic logic model_tick(input int k, input int p);
      return (k >= 1) && ((k % p) == 0);
   endfunction

   task automatic compare(input string tag, input int k, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
   endtask

   // One rising edge: drive reset, push model results, then compare after the edge.
   task automatic step(input logic r);
      int kk;
      reset = r;
      if (r) begin
         k7 = 0; k2 = 0; k32 = 0;
         valid = 1'b1;
      end else begin
         k7++; k2++; k32++;
      end
      if (valid) begin
         q7.push_back(model_tick(k7, 7));
         q2.push_back(model_tick(k2, 2));
         q32.push_back(model_tick(k32, 32));
         qk.push_back(k7);
         qk.push_back(k2);
         qk.push_back(k32);
      end
      @(posedge clock);
      #1;
      if (q7.size() != 0) begin
         kk = qk.pop_front();
         if (count7 === 1'b1) pulses7++;
         compare("p7", kk, count7, q7.pop_front());
         kk = qk.pop_front();
         compare("p2", kk, count2, q2.pop_front());
         kk = qk.pop_front();
         compare("p32", kk, count32, q32.pop_front());
      end
      @(negedge clock);
   endtask

   initial begin
      checks  = 0;
      passed  = 0;
      valid   = 1'b0;
      pulses7 = 0;
      k7 = 0; k2 = 0; k32 = 0;
      reset = 1'b0;
      @(negedge clock);

      // Free-run with no reset ever applied: nothing is checked yet.
      step(1'b0);
      step(1'b0);

      // Single reset edge, then 20 edges: p7 pulses only at 7 and 14.
      step(1'b1);
      pulses7 = 0;
      for (int i = 0; i < 20; i++) step(1'b0);
      checks++;
      assert (pulses7 == 2) passed++;
      else $error("FAIL p7_pulses_1_20 observed=%0d expected=%0d", pulses7, 2);

      // Restart, then reset mid-period on the 10th edge.
      step(1'b1);
      for (int i = 0; i < 9; i++) step(1'b0);
      step(1'b1);

      // Long run covers p7 restart, p2 alternation and p32 pulses at 32 and 64.
      for (int i = 0; i < 70; i++) step(1'b0);

      // Back-to-back reset edges hold everything low.
      step(1'b1);
      step(1'b1);
      for (int i = 0; i < 8; i++) step(1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
